// File: rtl/prog_load_pkg.sv
// Shared types and constants for the UART program loader.
//   state_e       : loader sequencer states
//   ERR_*         : err_code values reported on load_err / load_done
//   SYNC_BYTE_DEF : default frame start marker
package prog_load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEN  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/load_timeout_ctr.sv
// Loadable down-counter that measures idle time between received bytes.
//   clk, rst_n : clock, async active-low reset
//   load       : reload the counter with TIMEOUT_CYC (wins over en)
//   en         : decrement by one, saturating at zero
//   expired    : registered flag, high while the count is zero
module load_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload, saturating decrement or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(TIMEOUT_CYC);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // expired tracks cnt==0 as a register so the flag is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            expired <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            expired <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/prog_load_ctrl.sv
// UART boot-loader sequencer: parses SYNC, LEN, LEN payload bytes, CSUM and
// writes the payload into the program-memory slot latched at SYNC time,
// holding the core in reset for the duration of the load.
//   clk, rst_n         : clock, async active-low reset
//   rx_valid, rx_data  : one-cycle byte strobe from the UART receiver
//   slot_sel           : program slot to load, sampled on SYNC
//   mem_we/addr/wdata  : registered program-memory write port, addr = {slot, offset}
//   cpu_hold           : 1 while a frame is being loaded
//   load_done/load_err : one-cycle result pulses
//   err_code           : sticky result of the last frame (ERR_*)
module prog_load_ctrl
    import prog_load_pkg::*;
#(
    parameter int unsigned SLOT_W      = 2,
    parameter int unsigned OFFS_W      = 6,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic [SLOT_W-1:0]        slot_sel,
    output logic                     mem_we,
    output logic [SLOT_W+OFFS_W-1:0] mem_addr,
    output logic [7:0]               mem_wdata,
    output logic                     cpu_hold,
    output logic                     load_done,
    output logic                     load_err,
    output logic [1:0]               err_code
);

    localparam int unsigned ADDR_W  = SLOT_W + OFFS_W;
    localparam int unsigned LEN_W   = OFFS_W + 1;
    localparam int unsigned LEN_MAX = 2 ** OFFS_W;

    state_e              state_q,   state_d;
    logic [SLOT_W-1:0]   slot_q,    slot_d;
    logic [OFFS_W-1:0]   offs_q,    offs_d;
    logic [LEN_W-1:0]    rem_q,     rem_d;
    logic [7:0]          csum_q,    csum_d;
    logic                mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [7:0]          mem_wdata_d;
    logic                cpu_hold_d;
    logic                load_done_d;
    logic                load_err_d;
    logic [1:0]          err_code_d;

    logic                tmr_load_c;
    logic                tmr_en_c;
    logic                tmr_expired;
    logic                tmo_c;

    // Timer is held loaded in IDLE and reloaded on every byte inside a frame.
    assign tmr_load_c = (state_q == IDLE) || rx_valid;
    assign tmr_en_c   = (state_q != IDLE);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign tmo_c      = (state_q != IDLE) && !rx_valid && tmr_expired;

    load_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load_c),
        .en      (tmr_en_c),
        .expired (tmr_expired)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        offs_d      = offs_q;
        rem_d       = rem_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        cpu_hold_d  = cpu_hold;
        load_done_d = 1'b0;
        load_err_d  = 1'b0;
        err_code_d  = err_code;

        if (tmo_c) begin
            state_d    = IDLE;
            cpu_hold_d = 1'b0;
            load_err_d = 1'b1;
            err_code_d = ERR_TMO;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state_d    = LEN;
                        slot_d     = slot_sel;
                        offs_d     = '0;
                        csum_d     = 8'h00;
                        cpu_hold_d = 1'b1;
                    end
                end

                LEN: begin
                    if (rx_valid) begin
                        if (rx_data == 8'h00) begin
                            state_d = CSUM;
                            csum_d  = 8'h00;
                        end else if (32'(rx_data) <= LEN_MAX) begin
                            state_d = DATA;
                            rem_d   = LEN_W'(rx_data);
                            offs_d  = '0;
                            csum_d  = rx_data;
                        end else begin
                            state_d    = IDLE;
                            cpu_hold_d = 1'b0;
                            load_err_d = 1'b1;
                            err_code_d = ERR_LEN;
                        end
                    end
                end

                DATA: begin
                    if (rx_valid) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {slot_q, offs_q};
                        mem_wdata_d = rx_data;
                        csum_d      = csum_q + rx_data;
                        offs_d      = offs_q + OFFS_W'(1);
                        rem_d       = rem_q - LEN_W'(1);
                        // rem counts bytes still owed, so offs stays below len.
                        if (rem_q == LEN_W'(1)) begin
                            state_d = CSUM;
                        end
                    end
                end

                CSUM: begin
                    if (rx_valid) begin
                        state_d    = IDLE;
                        cpu_hold_d = 1'b0;
                        if (rx_data == csum_q) begin
                            load_done_d = 1'b1;
                            err_code_d  = ERR_NONE;
                        end else begin
                            load_err_d = 1'b1;
                            err_code_d = ERR_CSUM;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            offs_q    <= '0;
            rem_q     <= '0;
            csum_q    <= 8'h00;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            offs_q    <= offs_d;
            rem_q     <= rem_d;
            csum_q    <= csum_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            cpu_hold  <= cpu_hold_d;
            load_done <= load_done_d;
            load_err  <= load_err_d;
            err_code  <= err_code_d;
        end
    end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Scoreboard bench for prog_load_ctrl. The stimulus side builds whole frames
// and, from the frame rules alone (payload addresses, modulo-256 sum, length
// limit, idle-gap limit), queues the responses the loader must produce and
// the cycle each must appear in. A negedge monitor pops and compares.
module tb_prog_load_ctrl;

    localparam int unsigned SLOT_W = 2;
    localparam int unsigned OFFS_W = 6;
    localparam int unsigned T      = 40;
    localparam logic [7:0]  SYNC   = 8'hA5;

    // Event kinds: 0 write, 1 done pulse, 2 err pulse, 3 idle status, 4 all-zero
    typedef struct {
        int kind;
        int addr;
        int data;
        int code;
        int cyc;
    } ev_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     rx_valid = 1'b0;
    logic [7:0]               rx_data = 8'h00;
    logic [SLOT_W-1:0]        slot_sel = '0;
    logic                     mem_we;
    logic [SLOT_W+OFFS_W-1:0] mem_addr;
    logic [7:0]               mem_wdata;
    logic                     cpu_hold;
    logic                     load_done;
    logic                     load_err;
    logic [1:0]               err_code;

    ev_t exp_q[$];
    int  cyc = 0;
    int  last_cyc = 0;
    int  exp_code = 0;
    int  vectors = 0;
    int  miscompares = 0;

    prog_load_ctrl #(
        .SLOT_W      (SLOT_W),
        .OFFS_W      (OFFS_W),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .slot_sel  (slot_sel),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: run still active at cyc %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    task automatic check_out(input int kind, input int addr, input int data);
        ev_t e;
        int  hold_req;
        vectors++;
        hold_req = (kind == 0) ? 1 : 0;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_out: got kind=%0d addr=%02h data=%02h at cyc %0d, required nothing",
                     kind, addr, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc ||
                (kind == 0 && (e.addr != addr || e.data != data)) ||
                (kind != 0 && int'(err_code) != e.code) ||
                int'(cpu_hold) != hold_req) begin
                miscompares++;
                $display("FAIL out_event: got kind=%0d cyc=%0d addr=%02h data=%02h code=%0d hold=%0b, required kind=%0d cyc=%0d addr=%02h data=%02h code=%0d hold=%0d",
                         kind, cyc, addr, data, err_code, cpu_hold,
                         e.kind, e.cyc, e.addr, e.data, e.code, hold_req);
            end
        end
    endtask

    task automatic check_status(input ev_t e);
        logic ok;
        vectors++;
        ok = !mem_we && !load_done && !load_err &&
             (int'(cpu_hold) == e.data) && (int'(err_code) == e.code);
        if (e.kind == 4) ok = ok && (mem_addr == '0) && (mem_wdata == 8'h00);
        if (!ok) begin
            miscompares++;
            $display("FAIL status%0d: got we=%0b done=%0b err=%0b hold=%0b code=%0d addr=%02h wdata=%02h at cyc %0d, required pulses 0 hold=%0d code=%0d",
                     e.kind, mem_we, load_done, load_err, cpu_hold, err_code,
                     mem_addr, mem_wdata, cyc, e.data, e.code);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we)    check_out(0, int'(mem_addr), int'(mem_wdata));
        if (load_done) check_out(1, 0, 0);
        if (load_err)  check_out(2, 0, 0);
        while (exp_q.size() > 0 && exp_q[0].kind >= 3 && exp_q[0].cyc == cyc) begin
            check_status(exp_q.pop_front());
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got nothing by cyc %0d, required kind=%0d at cyc %0d addr=%02h data=%02h code=%0d",
                     cyc, exp_q[0].kind, exp_q[0].cyc, exp_q[0].addr, exp_q[0].data, exp_q[0].code);
            void'(exp_q.pop_front());
        end
    end

    // ---------------- stimulus and model ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input int addr, input int data,
                           input int code, input int c);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.code = code; e.cyc = c;
        exp_q.push_back(e);
        if (kind == 1 || kind == 2) exp_code = code;
    endtask

    // gap = number of idle cycles before the strobe.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        last_cyc = cyc;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic finish_frame();
        repeat (2) tick();
        push_ev(3, 0, 0, exp_code, cyc);
        tick();
    endtask

    // len is the raw LEN byte. stop_at: payload index (len = checksum slot)
    // at which the sender goes silent, -1 for none. gap_idx/gap_len force one
    // specific inter-byte gap. A gap longer than T cycles aborts the frame.
    task automatic run_frame(input int slot, input int len, input int csum_force,
                             input int stop_at, input int gap_idx, input int gap_len,
                             input bit toggle);
        logic [7:0] sum;
        logic [7:0] d;
        logic [7:0] c;
        int g;
        slot_sel = 2'(slot);
        send_byte(SYNC, $urandom_range(0, 2));
        push_ev(3, 0, 1, exp_code, cyc);
        send_byte(8'(len), $urandom_range(0, 3));
        if (len > 64) begin
            push_ev(2, 0, 0, 2, last_cyc + 1);
            finish_frame();
            return;
        end
        sum = 8'(len);
        for (int i = 0; i <= len; i++) begin
            g = (i == gap_idx) ? gap_len : int'($urandom_range(0, 3));
            if (i == stop_at) g = T + 1 + int'($urandom_range(0, 5));
            if (g > T) begin
                push_ev(2, 0, 0, 3, last_cyc + T + 2);
                repeat (g) tick();
                finish_frame();
                return;
            end
            if (i < len) begin
                d = 8'($urandom);
                send_byte(d, g);
                push_ev(0, slot * 64 + i, int'(d), 0, last_cyc + 1);
                sum = sum + d;
                if (toggle) slot_sel = 2'($urandom);
            end else begin
                c = (csum_force < 0) ? sum : 8'(csum_force);
                send_byte(c, g);
                if (c == sum) push_ev(1, 0, 0, 0, last_cyc + 1);
                else          push_ev(2, 0, 0, 1, last_cyc + 1);
            end
        end
        finish_frame();
    endtask

    task automatic send_junk(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            send_byte(b, $urandom_range(0, 2));
        end
        finish_frame();
    endtask

    initial begin
        logic [7:0] d;
        int k;
        int slot;
        int len;

        // reset state
        repeat (3) tick();
        push_ev(4, 0, 0, 0, cyc);
        tick();
        rst_n = 1'b1;
        tick();
        push_ev(4, 0, 0, 0, cyc);
        tick();

        // good 3-byte frame into slot 2 (addresses 0x80..0x82)
        run_frame(2, 3, -1, -1, -1, 0, 1'b0);
        // bad checksum 00 on a 2-byte frame
        run_frame(0, 2, 0, -1, -1, 0, 1'b0);
        // length 0x41 is over the slot size, then an empty image
        run_frame(1, 8'h41, -1, -1, -1, 0, 1'b0);
        run_frame(1, 0, -1, -1, -1, 0, 1'b0);
        // silent after first payload byte
        run_frame(3, 5, -1, 1, -1, 0, 1'b0);
        // gap of exactly T cycles survives, T+1 times out (payload and checksum)
        run_frame(0, 2, -1, -1, 1, T, 1'b0);
        run_frame(0, 2, -1, -1, 1, T + 1, 1'b0);
        run_frame(2, 2, -1, -1, 2, T, 1'b0);
        // junk in IDLE, then a full 64-byte slot with slot_sel toggling
        send_junk(3);
        run_frame(3, 64, -1, -1, -1, 0, 1'b1);
        run_frame(1, 1, -1, -1, -1, 0, 1'b1);

        // reset in the middle of a 40-byte frame
        slot_sel = 2'd1;
        send_byte(SYNC, 0);
        send_byte(8'd40, 0);
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            send_byte(d, $urandom_range(0, 1));
            push_ev(0, 64 + i, int'(d), 0, last_cyc + 1);
        end
        repeat (2) tick();
        push_ev(4, 0, 0, 0, cyc);
        rst_n = 1'b0;
        exp_code = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        push_ev(3, 0, 0, 0, cyc);
        tick();
        run_frame(2, 1, -1, -1, -1, 0, 1'b0);

        // randomized frames
        for (int n = 0; n < 50; n++) begin
            k    = $urandom_range(0, 9);
            slot = $urandom_range(0, 3);
            len  = $urandom_range(0, 64);
            if ($urandom_range(0, 3) == 0) send_junk($urandom_range(1, 3));
            case (k)
                0, 1, 2, 3: run_frame(slot, len, -1, -1, -1, 0, 1'b1);
                4, 5:       run_frame(slot, len, int'($urandom_range(0, 255)), -1, -1, 0, 1'b1);
                6:          run_frame(slot, int'($urandom_range(65, 255)), -1, -1, -1, 0, 1'b1);
                7:          run_frame(slot, len, -1, int'($urandom_range(0, len)), -1, 0, 1'b1);
                default:    run_frame(slot, len, -1, -1, int'($urandom_range(0, len)),
                                      int'($urandom_range(T - 3, T)), 1'b1);
            endcase
        end

        // let any outstanding expectation come due
        repeat (T + 10) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
